// File: rtl/cumsum_excl_stream.sv
// Streaming row-segmented prefix-sum engine: one element per cycle in, one
// exclusive or inclusive running sum per cycle out, with a single registered output stage.
module cumsum_excl_stream #(
    parameter int DATA_W  = 32,
    parameter int ROW_LEN = 16,
    parameter int IDX_W   = $clog2(ROW_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              mode_incl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [IDX_W-1:0]  out_idx
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              out_last_q,  out_last_d;
    logic [IDX_W-1:0]  out_idx_q,   out_idx_d;
    logic [DATA_W-1:0] acc_q,       acc_d;
    logic [IDX_W-1:0]  idx_q,       idx_d;
    logic              mode_q,      mode_d;

    logic              accept;
    logic              out_fire;
    logic              row_incl;
    logic              row_end;
    logic [DATA_W-1:0] sum;

    // The output register frees up in the same cycle it is drained, so no bubble.
    assign in_ready = !rst && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    assign row_incl = (idx_q == '0) ? mode_incl : mode_q;
    assign sum      = acc_q + in_data;
    assign row_end  = in_last || (idx_q == IDX_W'(ROW_LEN - 1));

    always_comb begin
        // NOTE: every next-state value starts from its held value so no path infers a latch.
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_idx_d   = out_idx_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        mode_d      = mode_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = row_incl ? sum : acc_q;
            out_last_d  = row_end;
            out_idx_d   = idx_q;
            mode_d      = row_incl;
            if (row_end) begin
                acc_d = '0;
                idx_d = '0;
            end else begin
                acc_d = sum;
                idx_d = idx_q + IDX_W'(1);
            end
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_idx_q   <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            mode_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_idx_q   <= out_idx_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            mode_q      <= mode_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_cumsum_excl_stream.sv
// Directed and randomized-handshake bench for cumsum_excl_stream; instance a is
// 32-bit with ROW_LEN=4, instance b is 8-bit with ROW_LEN=16 for wrap and early ends.
module tb_cumsum_excl_stream;

    localparam int DW   = 32;
    localparam int RL   = 4;
    localparam int IW   = 2;
    localparam int DW_B = 8;
    localparam int RL_B = 16;
    localparam int IW_B = 4;

    typedef struct {
        logic [31:0] din;
        logic        last;
        logic        mode;
        logic [31:0] exp_data;
        logic        exp_last;
        int          exp_idx;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          a_in_valid = 1'b0, a_in_ready, a_in_last = 1'b0, a_mode_incl = 1'b0;
    logic [DW-1:0] a_in_data = '0, a_out_data;
    logic          a_out_valid, a_out_ready = 1'b1, a_out_last;
    logic [IW-1:0] a_out_idx;

    logic            b_in_valid = 1'b0, b_in_ready, b_in_last = 1'b0, b_mode_incl = 1'b0;
    logic [DW_B-1:0] b_in_data = '0, b_out_data;
    logic            b_out_valid, b_out_ready = 1'b1, b_out_last;
    logic [IW_B-1:0] b_out_idx;

    cumsum_excl_stream #(.DATA_W(DW), .ROW_LEN(RL), .IDX_W(IW)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_last(a_in_last), .mode_incl(a_mode_incl),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_last(a_out_last), .out_idx(a_out_idx)
    );

    cumsum_excl_stream #(.DATA_W(DW_B), .ROW_LEN(RL_B), .IDX_W(IW_B)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_last(b_in_last), .mode_incl(b_mode_incl),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_last(b_out_last), .out_idx(b_out_idx)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] din, input logic last, input logic mode,
                                input logic [31:0] ed, input logic el, input int ei);
        vec_t v;
        v.din = din; v.last = last; v.mode = mode;
        v.exp_data = ed; v.exp_last = el; v.exp_idx = ei;
        return v;
    endfunction

    task automatic send_a(input vec_t v, input string tag);
        @(negedge clk);
        a_in_valid = 1'b1; a_in_data = v.din; a_in_last = v.last; a_mode_incl = v.mode;
        #1 check({tag, " in_ready"}, 64'(a_in_ready), 64'(1));
        @(posedge clk); #1;
        check({tag, " out_valid"}, 64'(a_out_valid), 64'(1));
        check({tag, " out_data"},  64'(a_out_data),  64'(v.exp_data));
        check({tag, " out_last"},  64'(a_out_last),  64'(v.exp_last));
        check({tag, " out_idx"},   64'(a_out_idx),   64'(v.exp_idx));
    endtask

    task automatic send_b(input vec_t v, input string tag);
        logic [DW_B-1:0] ed;
        ed = v.exp_data[DW_B-1:0];
        @(negedge clk);
        b_in_valid = 1'b1; b_in_data = v.din[DW_B-1:0]; b_in_last = v.last; b_mode_incl = v.mode;
        @(posedge clk); #1;
        check({tag, " out_valid"}, 64'(b_out_valid), 64'(1));
        check({tag, " out_data"},  64'(b_out_data),  64'(ed));
        check({tag, " out_last"},  64'(b_out_last),  64'(v.exp_last));
        check({tag, " out_idx"},   64'(b_out_idx),   64'(v.exp_idx));
    endtask

    vec_t tbl_a[$];
    vec_t tbl_b[$];

    // Reference model state for the randomized handshake run.
    logic [DW-1:0]      ref_acc;
    int                 ref_idx;
    logic               ref_mode;
    logic [DW+IW:0]     exp_q[$];

    initial begin
        logic [DW+IW:0] got, want, held_val;
        logic           held_v, incl, row_end;
        int             accepted, cycles;

        // Main table: exclusive rows, ROW_LEN wrap, early last, mode latching, one-element rows.
        tbl_a.push_back(mk(1, 0, 0, 0, 0, 0));
        tbl_a.push_back(mk(2, 0, 0, 1, 0, 1));
        tbl_a.push_back(mk(3, 0, 0, 3, 0, 2));
        tbl_a.push_back(mk(4, 0, 0, 6, 1, 3));
        tbl_a.push_back(mk(5, 0, 0, 0, 0, 0));
        tbl_a.push_back(mk(5, 0, 0, 5, 0, 1));
        tbl_a.push_back(mk(6, 1, 0, 10, 1, 2));
        tbl_a.push_back(mk(1, 0, 1, 1, 0, 0));
        tbl_a.push_back(mk(2, 0, 0, 3, 0, 1));
        tbl_a.push_back(mk(3, 0, 0, 6, 0, 2));
        tbl_a.push_back(mk(4, 0, 0, 10, 1, 3));
        tbl_a.push_back(mk(1, 0, 0, 0, 0, 0));
        tbl_a.push_back(mk(2, 1, 1, 1, 1, 1));
        tbl_a.push_back(mk(8, 1, 1, 8, 1, 0));
        tbl_a.push_back(mk(8, 1, 0, 0, 1, 0));
        tbl_a.push_back(mk(32'hFFFF_FFFB, 0, 1, 32'hFFFF_FFFB, 0, 0));
        tbl_a.push_back(mk(2, 1, 0, 32'hFFFF_FFFD, 1, 1));

        // 8-bit wrap (300 mod 256 = 44), then early termination and a fresh row.
        tbl_b.push_back(mk(200, 0, 0, 0, 0, 0));
        tbl_b.push_back(mk(100, 0, 0, 200, 0, 1));
        tbl_b.push_back(mk(50, 1, 0, 44, 1, 2));
        tbl_b.push_back(mk(7, 0, 0, 0, 0, 0));
        tbl_b.push_back(mk(32'hFFFF_FFFE, 0, 0, 7, 0, 1));
        tbl_b.push_back(mk(4, 1, 0, 5, 1, 2));
        tbl_b.push_back(mk(9, 0, 0, 0, 0, 0));
        tbl_b.push_back(mk(1, 1, 0, 9, 1, 1));

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst a in_ready",  64'(a_in_ready),  64'(0));
        check("rst b in_ready",  64'(b_in_ready),  64'(0));
        check("rst a out_valid", 64'(a_out_valid), 64'(0));
        check("rst a out_data",  64'(a_out_data),  64'(0));
        check("rst a out_last",  64'(a_out_last),  64'(0));
        check("rst a out_idx",   64'(a_out_idx),   64'(0));
        rst = 1'b0;
        #1 check("post-rst a in_ready", 64'(a_in_ready), 64'(1));

        for (int i = 0; i < tbl_a.size(); i++) send_a(tbl_a[i], $sformatf("a_vec%0d", i));
        @(negedge clk) a_in_valid = 1'b0;

        for (int i = 0; i < tbl_b.size(); i++) send_b(tbl_b[i], $sformatf("b_vec%0d", i));
        @(negedge clk) b_in_valid = 1'b0;

        // Backpressure: pending output held for 3 cycles, nothing accepted meanwhile.
        send_a(mk(10, 0, 0, 0, 0, 0), "bp_first");
        @(negedge clk);
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 20; a_in_last = 1'b1; a_mode_incl = 1'b0;
        #1 check("bp in_ready low", 64'(a_in_ready), 64'(0));
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp hold%0d out_valid", c), 64'(a_out_valid), 64'(1));
            check($sformatf("bp hold%0d out_data", c),  64'(a_out_data),  64'(0));
            check($sformatf("bp hold%0d out_idx", c),   64'(a_out_idx),   64'(0));
            check($sformatf("bp hold%0d in_ready", c),  64'(a_in_ready),  64'(0));
        end
        @(negedge clk);
        a_out_ready = 1'b1;
        #1 check("bp release in_ready", 64'(a_in_ready), 64'(1));
        @(posedge clk); #1;
        check("bp second out_data", 64'(a_out_data), 64'(10));
        check("bp second out_idx",  64'(a_out_idx),  64'(1));
        check("bp second out_last", 64'(a_out_last), 64'(1));
        @(negedge clk) a_in_valid = 1'b0;
        @(posedge clk); #1;
        check("bp drained out_valid", 64'(a_out_valid), 64'(0));

        // Reset mid-row discards the partial row.
        send_a(mk(3, 0, 0, 0, 0, 0), "mid_rst pre0");
        send_a(mk(4, 0, 0, 3, 0, 1), "mid_rst pre1");
        @(negedge clk);
        a_in_valid = 1'b0; rst = 1'b1;
        #1 check("mid_rst in_ready", 64'(a_in_ready), 64'(0));
        @(posedge clk); #1;
        check("mid_rst out_valid", 64'(a_out_valid), 64'(0));
        @(negedge clk) rst = 1'b0;
        send_a(mk(5, 0, 0, 0, 0, 0), "mid_rst post0");
        send_a(mk(6, 0, 0, 5, 0, 1), "mid_rst post1");

        @(negedge clk);
        a_in_valid = 1'b0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Random valid/ready over 1000 accepted elements against the reference model.
        ref_acc = '0; ref_idx = 0; ref_mode = 1'b0;
        accepted = 0; cycles = 0; held_v = 1'b0; held_val = '0;
        while (accepted < 1000 && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_in_data   = $urandom;
            a_in_last   = ($urandom_range(0, 7) == 0);
            a_mode_incl = $urandom_range(0, 1) != 0;
            a_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            got = {a_out_data, a_out_last, a_out_idx};
            if (held_v) check("rnd hold stable", 64'(got), 64'(held_val));
            check("rnd out_valid", 64'(a_out_valid), 64'(exp_q.size() != 0));
            check("rnd in_ready", 64'(a_in_ready), 64'(exp_q.size() == 0 || a_out_ready));
            held_v   = a_out_valid && !a_out_ready;
            held_val = got;
            if (a_out_valid && a_out_ready && exp_q.size() != 0) begin
                want = exp_q.pop_front();
                check("rnd out", 64'(got), 64'(want));
            end
            if (a_in_valid && a_in_ready) begin
                incl    = (ref_idx == 0) ? a_mode_incl : ref_mode;
                ref_mode = incl;
                row_end = a_in_last || (ref_idx == RL - 1);
                exp_q.push_back({incl ? ref_acc + a_in_data : ref_acc, row_end, IW'(ref_idx)});
                if (row_end) begin
                    ref_acc = '0; ref_idx = 0;
                end else begin
                    ref_acc = ref_acc + a_in_data; ref_idx++;
                end
                accepted++;
            end
        end
        if (cycles >= 20000) check("rnd cycle budget", 64'(accepted), 64'(1000));
        @(negedge clk);
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        #1;
        if (a_out_valid && exp_q.size() != 0) begin
            want = exp_q.pop_front();
            check("rnd drain out", 64'({a_out_data, a_out_last, a_out_idx}), 64'(want));
        end
        @(posedge clk); #1;
        check("rnd final out_valid", 64'(a_out_valid), 64'(0));
        check("rnd queue empty", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
